// File: rtl/slope_adc_sequencer_if.sv
// Handshake/result bundle between the single-slope ADC sequencer and its environment.
// The slave modport is the sequencer side; the master modport drives start/continuous/comp_in.
interface slope_adc_sequencer_if #(
    parameter int CNT_W = 12
);
    logic             start;
    logic             continuous;
    logic             comp_in;
    logic             ramp_discharge;
    logic             ramp_en;
    logic             busy;
    logic [CNT_W-1:0] sample;
    logic             sample_valid;
    logic             overflow;
    logic             comp_stuck;

    modport master (
        output start, continuous, comp_in,
        input  ramp_discharge, ramp_en, busy, sample, sample_valid, overflow, comp_stuck
    );

    modport slave (
        input  start, continuous, comp_in,
        output ramp_discharge, ramp_en, busy, sample, sample_valid, overflow, comp_stuck
    );
endinterface

// File: rtl/slope_adc_sequencer.sv
// Single-slope ADC sequencer: discharge ramp, run ramp, time comparator trip, publish count.
// Optional feature macro: SLOPE_ADC_DEGLITCH_EN (trip/stuck require two consecutive comp_s highs).
module slope_adc_sequencer #(
    parameter int CNT_W        = 12,
    parameter int DISCH_CYCLES = 64,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    slope_adc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DISCHARGE, RAMP, DONE} state_t;

    localparam int               DW       = $clog2(DISCH_CYCLES);
    localparam logic [DW-1:0]    DLAST    = DW'(DISCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t                 state;
    logic [DW-1:0]          dcnt;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   comp_s;
    logic                   trip;
    logic                   stuck;

    logic                   ramp_discharge;
    logic                   ramp_en;
    logic                   busy;
    logic [CNT_W-1:0]       sample;
    logic                   sample_valid;
    logic                   overflow;
    logic                   comp_stuck;

    // comp_in is asynchronous to clk; nothing downstream may look at it before this chain.
    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], bus.comp_in};
    end
    assign comp_s = sync[SYNC_STAGES-1];

`ifdef SLOPE_ADC_DEGLITCH_EN
    logic comp_q;

    always_ff @(posedge clk) begin
        if (rst) comp_q <= 1'b0;
        else     comp_q <= comp_s;
    end
    // cnt != 0 keeps the pair inside RAMP: the previous cycle of count 0 is still DISCHARGE.
    assign trip  = comp_s & comp_q & (cnt != '0);
    assign stuck = comp_s & comp_q;
`else
    assign trip  = comp_s;
    assign stuck = comp_s;
`endif

    // NOTE: every state/output update here is non-blocking, so all branches see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            dcnt           <= '0;
            cnt            <= '0;
            ramp_discharge <= 1'b1;
            ramp_en        <= 1'b0;
            busy           <= 1'b0;
            sample         <= '0;
            sample_valid   <= 1'b0;
            overflow       <= 1'b0;
            comp_stuck     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= DISCHARGE;
                        dcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                DISCHARGE: begin
                    if (dcnt == DLAST) begin
                        dcnt <= '0;
                        if (stuck) begin
                            state        <= DONE;
                            sample       <= '0;
                            comp_stuck   <= 1'b1;
                            overflow     <= 1'b0;
                            sample_valid <= 1'b1;
                        end else begin
                            state          <= RAMP;
                            cnt            <= '0;
                            ramp_discharge <= 1'b0;
                            ramp_en        <= 1'b1;
                        end
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                RAMP: begin
                    // A trip on the full-scale count still wins over overflow.
                    if (trip || cnt == CNT_MAX) begin
                        state          <= DONE;
                        sample         <= trip ? cnt : CNT_MAX;
                        overflow       <= ~trip;
                        comp_stuck     <= 1'b0;
                        sample_valid   <= 1'b1;
                        ramp_en        <= 1'b0;
                        ramp_discharge <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.continuous) begin
                        state <= DISCHARGE;
                        dcnt  <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ramp_discharge = ramp_discharge;
    assign bus.ramp_en        = ramp_en;
    assign bus.busy           = busy;
    assign bus.sample         = sample;
    assign bus.sample_valid   = sample_valid;
    assign bus.overflow       = overflow;
    assign bus.comp_stuck     = comp_stuck;
endmodule

// File: tb/tb_slope_adc_sequencer.sv
// Directed bench for slope_adc_sequencer with CNT_W=8, DISCH_CYCLES=4, SYNC_STAGES=2.
// Expected trip results carry a +1 offset when SLOPE_ADC_DEGLITCH_EN is defined.
module tb_slope_adc_sequencer;
    localparam int CNT_W = 8;
    localparam int DISCH = 4;
    localparam int SYNC  = 2;
`ifdef SLOPE_ADC_DEGLITCH_EN
    localparam int DG = 1;
`else
    localparam int DG = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    slope_adc_sequencer_if #(.CNT_W(CNT_W)) bus ();

    slope_adc_sequencer #(
        .CNT_W(CNT_W), .DISCH_CYCLES(DISCH), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Leaves the bench in the first RAMP cycle (count 0).
    task automatic wait_ramp(input string tag);
        int k = 0;
        while (!bus.ramp_en && k < 1000) begin
            tick();
            k++;
        end
        check(tag, bus.ramp_en, 1);
    endtask

    // Leaves the bench in the DONE cycle; rc counts ramp_en cycles seen on the way.
    task automatic run_until_valid(input string tag, output int rc);
        int k = 0;
        rc = 0;
        while (!bus.sample_valid && k < 2000) begin
            if (bus.ramp_en) rc++;
            tick();
            k++;
        end
        check(tag, bus.sample_valid, 1);
    endtask

    // ramp_en and ramp_discharge must never overlap.
    always @(negedge clk) begin
        if (mon_en) check("excl", bus.ramp_en & bus.ramp_discharge, 0);
    end

    initial begin
        int n;
        int rc;

        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        bus.comp_in    = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        check("rst_disch", bus.ramp_discharge, 1);
        check("rst_ramp_en", bus.ramp_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sample", bus.sample, 0);
        check("rst_valid", bus.sample_valid, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_stuck", bus.comp_stuck, 0);
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // 1: basic conversion, trip at count 100
        pulse_start();
        check("t1_busy", bus.busy, 1);
        n = 0;
        for (int i = 0; i < 20 && !bus.ramp_en; i++) begin
            if (bus.ramp_discharge && bus.busy) n++;
            tick();
        end
        check("t1_disch_cycles", n, DISCH);
        check("t1_ramp_en", bus.ramp_en, 1);
        repeat (100) tick();
        bus.comp_in = 1'b1;
        run_until_valid("t1_timeout", rc);
        check("t1_sample", bus.sample, 102 + DG);
        check("t1_ovf", bus.overflow, 0);
        check("t1_stuck", bus.comp_stuck, 0);
        tick();
        bus.comp_in = 1'b0;
        check("t1_valid_once", bus.sample_valid, 0);
        check("t1_idle", bus.busy, 0);
        repeat (4) tick();

        // 2: no trip -> saturate
        pulse_start();
        run_until_valid("t2_timeout", rc);
        check("t2_ramp_cycles", rc, 256);
        check("t2_sample", bus.sample, 255);
        check("t2_ovf", bus.overflow, 1);
        tick();
        check("t2_valid_once", bus.sample_valid, 0);
        check("t2_idle", bus.busy, 0);
        check("t2_hold", bus.sample, 255);

        // 3: comparator stuck high
        bus.comp_in = 1'b1;
        repeat (4) tick();
        pulse_start();
        run_until_valid("t3_timeout", rc);
        check("t3_ramp_cycles", rc, 0);
        check("t3_ramp_en", bus.ramp_en, 0);
        check("t3_sample", bus.sample, 0);
        check("t3_stuck", bus.comp_stuck, 1);
        check("t3_ovf", bus.overflow, 0);
        bus.comp_in = 1'b0;
        tick();
        check("t3_idle", bus.busy, 0);
        repeat (4) tick();

        // 4: continuous mode, trips at 10 then 20
        bus.continuous = 1'b1;
        pulse_start();
        wait_ramp("t4a_ramp");
        repeat (10) tick();
        bus.comp_in = 1'b1;
        run_until_valid("t4a_timeout", rc);
        check("t4a_sample", bus.sample, 12 + DG);
        bus.comp_in = 1'b0;
        n = 0;
        for (int i = 0; i < DISCH; i++) begin
            tick();
            if (bus.ramp_discharge && !bus.ramp_en && bus.busy && !bus.sample_valid) n++;
        end
        check("t4_chain_disch", n, DISCH);
        tick();
        check("t4b_ramp_en", bus.ramp_en, 1);
        repeat (20) tick();
        bus.comp_in    = 1'b1;
        bus.continuous = 1'b0;
        run_until_valid("t4b_timeout", rc);
        check("t4b_sample", bus.sample, 22 + DG);
        bus.comp_in = 1'b0;
        tick();
        check("t4_idle", bus.busy, 0);
        repeat (4) tick();

        // 5: reset mid-ramp, start while busy ignored
        pulse_start();
        wait_ramp("t5a_ramp");
        repeat (5) tick();
        pulse_start();
        repeat (44) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_disch", bus.ramp_discharge, 1);
        check("t5_ramp_en", bus.ramp_en, 0);
        check("t5_busy", bus.busy, 0);
        check("t5_sample", bus.sample, 0);
        check("t5_valid", bus.sample_valid, 0);
        check("t5_ovf", bus.overflow, 0);
        check("t5_stuck", bus.comp_stuck, 0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.sample_valid || bus.busy) n++;
            tick();
        end
        check("t5_quiet", n, 0);
        pulse_start();
        wait_ramp("t5b_ramp");
        repeat (5) tick();
        pulse_start();
        repeat (34) tick();
        bus.comp_in = 1'b1;
        run_until_valid("t5b_timeout", rc);
        check("t5b_sample", bus.sample, 42 + DG);
        bus.comp_in = 1'b0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t5_done_start_ignored", bus.busy, 0);
        tick();
        check("t5_still_idle", bus.busy, 0);
        repeat (4) tick();

        // 6: one-cycle glitch at count 30, sustained rise at 60
        pulse_start();
        wait_ramp("t6_ramp");
        repeat (30) tick();
        bus.comp_in = 1'b1;
        tick();
        bus.comp_in = 1'b0;
`ifdef SLOPE_ADC_DEGLITCH_EN
        repeat (29) tick();
        bus.comp_in = 1'b1;
        run_until_valid("t6_timeout", rc);
        check("t6_sample", bus.sample, 63);
`else
        run_until_valid("t6_timeout", rc);
        check("t6_sample", bus.sample, 32);
`endif
        check("t6_ovf", bus.overflow, 0);
        bus.comp_in = 1'b0;
        tick();
        check("t6_idle", bus.busy, 0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
